// File: rtl/compact_pack.sv
// ============================================================================
// Module   : compact_pack
// Brief    : Stable valid-lane compactor plus cross-beat packer producing
//            dense output beats; partial residue flushed on segment last.
//            Optional statistics counters: define COMPACT_PACK_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module compact_pack #(
    parameter int  LANES  = 8,
    parameter int  DATA_W = 32,
    parameter int  CTRL_W = 2,
    localparam int CNT_W  = $clog2(LANES) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [LANES-1:0]        in_mask,
    input  logic                    in_last,
    input  logic [CTRL_W-1:0]       in_ctrl,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [LANES-1:0]        out_mask,
    output logic [CNT_W-1:0]        out_count,
    output logic                    out_last,
    output logic [CTRL_W-1:0]       out_ctrl
`ifdef COMPACT_PACK_STATS_EN
    ,
    output logic [31:0]             stat_words_in,
    output logic [31:0]             stat_beats_out,
    output logic [31:0]             stat_stall_cycles
`endif
);

    localparam int         c_BEAT_W   = LANES * DATA_W;
    localparam logic [0:0] c_ST_RUN   = 1'b0;
    localparam logic [0:0] c_ST_FLUSH = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_next;

    logic                r_a_valid;
    logic [c_BEAT_W-1:0] r_a_data;
    logic [CNT_W-1:0]    r_a_cnt;
    logic                r_a_last;
    logic [CTRL_W-1:0]   r_a_ctrl;

    logic [c_BEAT_W-1:0] r_res_data;
    logic [CNT_W-1:0]    r_res_cnt;
    logic [CTRL_W-1:0]   r_flush_ctrl;

    logic                r_out_valid;
    logic [c_BEAT_W-1:0] r_out_data;
    logic [LANES-1:0]    r_out_mask;
    logic [CNT_W-1:0]    r_out_count;
    logic                r_out_last;
    logic [CTRL_W-1:0]   r_out_ctrl;

    logic                w_out_free;
    logic                w_a_consume;
    logic                w_flush_fire;
    logic                w_in_fire;

    logic [c_BEAT_W-1:0]   w_cmp_data;
    logic [CNT_W-1:0]      w_cmp_cnt;
    logic [CNT_W-1:0]      w_tot;
    logic                  w_full;
    logic [31:0]           w_res_shamt;
    logic [2*c_BEAT_W-1:0] w_comb;
    logic [c_BEAT_W-1:0]   w_comb_lo;
    logic [c_BEAT_W-1:0]   w_comb_hi;

    logic                w_emit;
    logic [c_BEAT_W-1:0] w_emit_data;
    logic [CNT_W-1:0]    w_emit_cnt;
    logic [LANES-1:0]    w_emit_mask;
    logic                w_emit_last;
    logic [CTRL_W-1:0]   w_emit_ctrl;
    logic [c_BEAT_W-1:0] w_res_next_data;
    logic [CNT_W-1:0]    w_res_next_cnt;
    logic                w_go_flush;

    assign w_out_free   = !r_out_valid || out_ready;
    assign w_a_consume  = (r_state == c_ST_RUN) && r_a_valid && w_out_free;
    assign w_flush_fire = (r_state == c_ST_FLUSH) && w_out_free;
    assign w_in_fire    = in_valid && in_ready;

    // Stable compaction: each valid lane lands at the count of valid lanes below it.
    always_comb begin
        w_cmp_data = '0;
        w_cmp_cnt  = '0;
        for (int i = 0; i < LANES; i++) begin
            if (in_mask[i]) begin
                w_cmp_data[int'(w_cmp_cnt) * DATA_W +: DATA_W] = in_data[i*DATA_W +: DATA_W];
                w_cmp_cnt = w_cmp_cnt + CNT_W'(1);
            end
        end
    end

    // Residue lanes at or above r_res_cnt are kept zero, so OR-merging is exact.
    assign w_tot       = r_res_cnt + r_a_cnt;
    assign w_full      = (w_tot >= CNT_W'(LANES));
    assign w_res_shamt = 32'(r_res_cnt) * 32'(DATA_W);
    assign w_comb      = ({{c_BEAT_W{1'b0}}, r_a_data} << w_res_shamt)
                       | {{c_BEAT_W{1'b0}}, r_res_data};
    assign w_comb_lo   = w_comb[c_BEAT_W-1:0];
    assign w_comb_hi   = w_comb[2*c_BEAT_W-1:c_BEAT_W];

    always_comb begin
        w_emit          = 1'b0;
        w_emit_data     = w_comb_lo;
        w_emit_cnt      = w_tot;
        w_emit_last     = 1'b0;
        w_emit_ctrl     = r_a_ctrl;
        w_res_next_data = r_res_data;
        w_res_next_cnt  = r_res_cnt;
        w_go_flush      = 1'b0;
        if (w_flush_fire) begin
            w_emit          = 1'b1;
            w_emit_data     = r_res_data;
            w_emit_cnt      = r_res_cnt;
            w_emit_last     = 1'b1;
            w_emit_ctrl     = r_flush_ctrl;
            w_res_next_data = '0;
            w_res_next_cnt  = '0;
        end else if (w_a_consume) begin
            if (w_full) begin
                w_emit          = 1'b1;
                w_emit_cnt      = CNT_W'(LANES);
                w_emit_last     = r_a_last && (w_tot == CNT_W'(LANES));
                w_res_next_data = w_comb_hi;
                w_res_next_cnt  = w_tot - CNT_W'(LANES);
                w_go_flush      = r_a_last && (w_tot != CNT_W'(LANES));
            end else if (r_a_last) begin
                w_emit          = 1'b1;
                w_emit_last     = 1'b1;
                w_res_next_data = '0;
                w_res_next_cnt  = '0;
            end else begin
                w_res_next_data = w_comb_lo;
                w_res_next_cnt  = w_tot;
            end
        end
    end

    always_comb begin
        w_emit_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            w_emit_mask[i] = (CNT_W'(i) < w_emit_cnt);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_RUN:   if (w_go_flush)   w_state_next = c_ST_FLUSH;
            c_ST_FLUSH: if (w_flush_fire) w_state_next = c_ST_RUN;
            default:    w_state_next = c_ST_RUN;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready = 1'b0;
        if (!rst && (r_state == c_ST_RUN)) begin
            in_ready = !r_a_valid || w_a_consume;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_valid    <= 1'b0;
            r_a_data     <= '0;
            r_a_cnt      <= '0;
            r_a_last     <= 1'b0;
            r_a_ctrl     <= '0;
            r_res_data   <= '0;
            r_res_cnt    <= '0;
            r_flush_ctrl <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_mask   <= '0;
            r_out_count  <= '0;
            r_out_last   <= 1'b0;
            r_out_ctrl   <= '0;
        end else begin
            if (w_in_fire) begin
                r_a_valid <= 1'b1;
                r_a_data  <= w_cmp_data;
                r_a_cnt   <= w_cmp_cnt;
                r_a_last  <= in_last;
                r_a_ctrl  <= in_ctrl;
            end else if (w_a_consume) begin
                r_a_valid <= 1'b0;
            end
            r_res_data <= w_res_next_data;
            r_res_cnt  <= w_res_next_cnt;
            if (w_go_flush) begin
                r_flush_ctrl <= r_a_ctrl;
            end
            if (w_out_free) begin
                r_out_valid <= w_emit;
                if (w_emit) begin
                    r_out_data  <= w_emit_data;
                    r_out_mask  <= w_emit_mask;
                    r_out_count <= w_emit_cnt;
                    r_out_last  <= w_emit_last;
                    r_out_ctrl  <= w_emit_ctrl;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_mask  = r_out_mask;
    assign out_count = r_out_count;
    assign out_last  = r_out_last;
    assign out_ctrl  = r_out_ctrl;

`ifdef COMPACT_PACK_STATS_EN
    logic [31:0] r_stat_words_in;
    logic [31:0] r_stat_beats_out;
    logic [31:0] r_stat_stall_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_words_in     <= '0;
            r_stat_beats_out    <= '0;
            r_stat_stall_cycles <= '0;
        end else begin
            if (w_in_fire) begin
                r_stat_words_in <= r_stat_words_in + 32'(w_cmp_cnt);
            end
            if (r_out_valid && out_ready) begin
                r_stat_beats_out <= r_stat_beats_out + 32'd1;
            end
            if (r_out_valid && !out_ready) begin
                r_stat_stall_cycles <= r_stat_stall_cycles + 32'd1;
            end
        end
    end

    assign stat_words_in     = r_stat_words_in;
    assign stat_beats_out    = r_stat_beats_out;
    assign stat_stall_cycles = r_stat_stall_cycles;
`endif

endmodule

`default_nettype wire
